// File: rtl/i2c_xfer_seq_pkg.sv
// Shared definitions for the I2C register-transaction sequencer: i2c_master
// command/status bit layout, error codes and FSM state encodings.
package i2c_pkg;

  localparam int C_SZ = 5;
  localparam int S_SZ = 7;

  // Command bit positions and one-hot masks
  localparam int CB_STRT = 0;
  localparam int CB_STOP = 1;
  localparam int CB_READ = 2;
  localparam int CB_WRTE = 3;
  localparam int CB_NACK = 4;

  localparam logic [C_SZ-1:0] C_STRT = 5'b00001;
  localparam logic [C_SZ-1:0] C_STOP = 5'b00010;
  localparam logic [C_SZ-1:0] C_READ = 5'b00100;
  localparam logic [C_SZ-1:0] C_WRTE = 5'b01000;
  localparam logic [C_SZ-1:0] C_NACK = 5'b10000;

  // Status bit positions and one-hot masks
  localparam int SB_DON = 0;
  localparam int SB_ERR = 1;
  localparam int SB_ALO = 2;
  localparam int SB_BBL = 3;
  localparam int SB_ACK = 4;
  localparam int SB_BSY = 5;
  localparam int SB_BBY = 6;

  localparam logic [S_SZ-1:0] S_DON = 7'h01;
  localparam logic [S_SZ-1:0] S_ERR = 7'h02;
  localparam logic [S_SZ-1:0] S_ALO = 7'h04;
  localparam logic [S_SZ-1:0] S_BBL = 7'h08;
  localparam logic [S_SZ-1:0] S_ACK = 7'h10;
  localparam logic [S_SZ-1:0] S_BSY = 7'h20;
  localparam logic [S_SZ-1:0] S_BBY = 7'h40;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_ALO  = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_ADDRW = 4'd1;
  localparam state_t ST_REG   = 4'd2;
  localparam state_t ST_DATW  = 4'd3;
  localparam state_t ST_ADDRR = 4'd4;
  localparam state_t ST_DATR  = 4'd5;
  localparam state_t ST_GAP   = 4'd6;
  localparam state_t ST_WAIT  = 4'd7;
  localparam state_t ST_CHECK = 4'd8;
  localparam state_t ST_STOPC = 4'd9;
  localparam state_t ST_FIN   = 4'd10;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rnw);
    return {dev, rnw};
  endfunction

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Bundle of host request/data signals and i2c_master command/status signals.
// slave = the sequencer's view; master = host plus i2c_master side.
interface i2c_xfer_seq_if #(
  parameter int LEN_W = 4
);
  import i2c_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_rnw;
  logic [6:0]       req_dev;
  logic [7:0]       req_reg;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic [1:0]       err;
  logic [C_SZ-1:0]  m_cmd;
  logic             m_ws;
  logic [7:0]       m_dat;
  logic [S_SZ-1:0]  m_stat;
  logic [7:0]       m_dat_in;

  modport slave (
    input  req_valid, req_rnw, req_dev, req_reg, req_len, wr_data, wr_valid, m_stat, m_dat_in,
    output req_ready, wr_ready, rd_data, rd_valid, done, err, m_cmd, m_ws, m_dat
  );

  modport master (
    output req_valid, req_rnw, req_dev, req_reg, req_len, wr_data, wr_valid, m_stat, m_dat_in,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err, m_cmd, m_ws, m_dat
  );

endinterface

// File: rtl/i2c_xfer_seq.sv
// Register-transaction sequencer driving i2c_master's cmd/ws/stat handshake.
// Optional restart on early arbitration/bus errors: define I2C_SEQ_RETRY_EN.
module i2c_xfer_seq
  import i2c_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int RETRY_N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  i2c_xfer_seq_if.slave  bus
);

  state_t          state;
  state_t          phase;
  logic            rnw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q;
  logic [LEN_W-1:0] cnt;
  logic [C_SZ-1:0] cmd_q;
  logic [7:0]      dat_q;
  logic            ws_q;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            done_q;
  logic [1:0]      err_q;
  logic            progress;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = $clog2(RETRY_N + 2);
  logic [LEN_W-1:0] len_q;
  logic [RW-1:0]    retry_cnt;
`endif

  logic bus_free;
  logic wr_take;
  logic ck_alo;
  logic ck_err;
  logic ck_nack;
  logic last;
  logic unused_stat;

  assign bus_free = !bus.m_stat[SB_BSY];
  assign wr_take  = (state == ST_DATW) && bus.wr_valid && bus_free;
  assign ck_alo   = |(bus.m_stat & S_ALO);
  assign ck_err   = |(bus.m_stat & (S_ERR | S_BBL));
  assign ck_nack  = cmd_q[CB_WRTE] && !bus.m_stat[SB_ACK];
  assign last     = (cnt == LEN_W'(1));
  assign unused_stat = &{1'b0, bus.m_stat[SB_DON], bus.m_stat[SB_BBY]};

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.wr_ready  = wr_take;
  assign bus.m_cmd     = cmd_q;
  assign bus.m_dat     = dat_q;
  assign bus.m_ws      = ws_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // NOTE: sequential state uses <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= ST_IDLE;
      rnw_q      <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      cnt        <= '0;
      cmd_q      <= '0;
      dat_q      <= '0;
      ws_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      progress   <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      len_q      <= '0;
      retry_cnt  <= '0;
`endif
    end else begin
      ws_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;

      case (state)
        ST_IDLE: if (bus.req_valid) begin
          rnw_q    <= bus.req_rnw;
          dev_q    <= bus.req_dev;
          reg_q    <= bus.req_reg;
          cnt      <= bus.req_len;
          err_q    <= ERR_OK;
          progress <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
          len_q     <= bus.req_len;
          retry_cnt <= '0;
`endif
          // A zero-length read has no legal bus encoding; reject without traffic.
          if (bus.req_rnw && bus.req_len == '0) begin
            err_q <= ERR_BUSY;
            state <= ST_FIN;
          end else begin
            state <= ST_ADDRW;
          end
        end

        ST_ADDRW: if (bus_free) begin
          cmd_q <= C_STRT | C_WRTE;
          dat_q <= addr_byte(dev_q, 1'b0);
          ws_q  <= 1'b1;
          phase <= ST_ADDRW;
          state <= ST_GAP;
        end

        ST_REG: if (bus_free) begin
          cmd_q <= (!rnw_q && cnt == '0) ? (C_WRTE | C_STOP) : C_WRTE;
          dat_q <= reg_q;
          ws_q  <= 1'b1;
          phase <= ST_REG;
          state <= ST_GAP;
        end

        // Staying here without issuing leaves the master idle with SCL low.
        ST_DATW: if (wr_take) begin
          cmd_q    <= last ? (C_WRTE | C_STOP) : C_WRTE;
          dat_q    <= bus.wr_data;
          cnt      <= cnt - LEN_W'(1);
          progress <= 1'b1;
          ws_q     <= 1'b1;
          phase    <= ST_DATW;
          state    <= ST_GAP;
        end

        ST_ADDRR: if (bus_free) begin
          cmd_q <= C_STRT | C_WRTE;
          dat_q <= addr_byte(dev_q, 1'b1);
          ws_q  <= 1'b1;
          phase <= ST_ADDRR;
          state <= ST_GAP;
        end

        ST_DATR: if (bus_free) begin
          cmd_q <= last ? (C_READ | C_NACK | C_STOP) : C_READ;
          cnt   <= cnt - LEN_W'(1);
          ws_q  <= 1'b1;
          phase <= ST_DATR;
          state <= ST_GAP;
        end

        ST_STOPC: if (bus_free) begin
          cmd_q <= C_STOP;
          ws_q  <= 1'b1;
          phase <= ST_STOPC;
          state <= ST_GAP;
        end

        // BSY is only guaranteed one cycle after ws, so skip a cycle first.
        ST_GAP:  state <= ST_WAIT;
        ST_WAIT: if (bus_free) state <= ST_CHECK;

        ST_CHECK: begin
          if (phase == ST_STOPC) begin
            state <= ST_FIN;
          end else if (ck_alo || ck_err) begin
`ifdef I2C_SEQ_RETRY_EN
            if (!progress && retry_cnt < RW'(RETRY_N)) begin
              if (!bus.m_stat[SB_BBY]) begin
                retry_cnt <= retry_cnt + RW'(1);
                cnt       <= len_q;
                state     <= ST_ADDRW;
              end
            end else
`endif
            begin
              // The master has already released the bus: no STOP follows.
              err_q <= ck_alo ? ERR_ALO : ERR_BUSY;
              state <= ST_FIN;
            end
          end else if (ck_nack) begin
            err_q <= ERR_NACK;
            state <= ST_STOPC;
          end else begin
            case (phase)
              ST_ADDRW: state <= ST_REG;
              ST_REG:   state <= rnw_q ? ST_ADDRR : ((cnt == '0) ? ST_FIN : ST_DATW);
              ST_DATW:  state <= (cnt == '0) ? ST_FIN : ST_DATW;
              ST_ADDRR: state <= ST_DATR;
              ST_DATR: begin
                rd_data_q  <= bus.m_dat_in;
                rd_valid_q <= 1'b1;
                progress   <= 1'b1;
                state      <= (cnt == '0) ? ST_FIN : ST_DATR;
              end
              default:  state <= ST_FIN;
            endcase
          end
        end

        ST_FIN: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq with a command-level i2c_master/slave model
// (slave at 7'h50). Expectations follow I2C_SEQ_RETRY_EN when defined.
module tb_i2c_xfer_seq;
  import i2c_pkg::*;

  localparam int LEN_W    = 4;
  localparam int BUSY_LAT = 4;

  logic clk;
  logic rst_n;

  i2c_xfer_seq_if #(.LEN_W(LEN_W)) bus ();

  i2c_xfer_seq #(.LEN_W(LEN_W), .RETRY_N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Master/slave model state
  int         cmd_log[$];
  int         dat_log[$];
  logic [7:0] rdq[$];
  int         busy_cnt  = 0;
  int         bby_cnt   = 0;
  int         alo_left  = 0;
  int         bbl_left  = 0;
  int         ws_viol   = 0;
  logic [C_SZ-1:0] cur_cmd;
  logic [7:0]      cur_dat;

  task automatic finish_cmd();
    logic [S_SZ-1:0] st;
    st = S_DON | (bus.m_stat & S_BBY);
    if (cur_cmd[CB_STRT] && bbl_left > 0) begin
      bbl_left--;
      st = st | S_ERR | S_BBL;
    end else if (cur_cmd[CB_STRT] && alo_left > 0) begin
      alo_left--;
      st = st | S_ERR | S_ALO | S_BBY;
      bby_cnt = 10;
    end else begin
      if (cur_cmd[CB_WRTE]) begin
        if (!cur_cmd[CB_STRT] || cur_dat[7:1] == 7'h50) st = st | S_ACK;
      end
      if (cur_cmd[CB_READ]) bus.m_dat_in = (rdq.size() > 0) ? rdq.pop_front() : 8'hEE;
    end
    bus.m_stat = st;
  endtask

  initial begin
    bus.m_stat   = '0;
    bus.m_dat_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bby_cnt > 0) begin
        bby_cnt--;
        if (bby_cnt == 0) bus.m_stat[SB_BBY] = 1'b0;
      end
      if (busy_cnt > 0) begin
        if (bus.m_ws) ws_viol++;
        busy_cnt--;
        if (busy_cnt == 0) finish_cmd();
      end else if (bus.m_ws) begin
        if (bus.m_stat[SB_BSY]) ws_viol++;
        cur_cmd = bus.m_cmd;
        cur_dat = bus.m_dat;
        cmd_log.push_back(int'(bus.m_cmd));
        dat_log.push_back(int'(bus.m_dat));
        bus.m_stat[SB_BSY] = 1'b1;
        bus.m_stat[SB_DON] = 1'b0;
        busy_cnt = BUSY_LAT;
      end
    end
  end

  // Host-side state shared with the transaction task
  logic [7:0] wq[$];
  logic [7:0] rd_got[$];
  int         wr_taken;
  logic [1:0] err_got;
  int         busy_acc;
  int         stall_ws_a;
  int         stall_ws_b;
  int         exp_q[$];

  task automatic check_cmds(input string tag);
    check({tag, "_ncmd"}, 32'(cmd_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[i]), 32'(exp_q[i]));
  endtask

  task automatic run_xfer(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input int len, input int stall_before, input int stall_cyc,
                          input bit poke, input string tag);
    int  idx;
    int  stall_left;
    bit  got_done;
    cmd_log.delete();
    dat_log.delete();
    rd_got.delete();
    busy_acc   = 0;
    stall_ws_a = -1;
    stall_ws_b = -2;
    err_got    = 2'bxx;
    idx        = 0;
    stall_left = stall_cyc;
    got_done   = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_rnw   = rnw;
    bus.req_dev   = dev;
    bus.req_reg   = rg;
    bus.req_len   = LEN_W'(len);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
      if (idx < wq.size() && !(idx == stall_before && stall_left > 0)) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wq[idx];
      end else begin
        bus.wr_valid = 1'b0;
        if (idx == stall_before && stall_left > 0) begin
          if (stall_left == stall_cyc - 5) stall_ws_a = cmd_log.size();
          if (stall_left == 1) stall_ws_b = cmd_log.size();
          stall_left--;
        end
      end
      if (poke) begin
        bus.req_valid = (cyc >= 4 && cyc < 14);
        bus.req_rnw   = 1'b1;
        bus.req_len   = LEN_W'(3);
      end
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) busy_acc++;
      if (bus.wr_ready) idx++;
      if (bus.rd_valid) rd_got.push_back(bus.rd_data);
      if (bus.done) begin
        got_done = 1'b1;
        err_got  = bus.err;
      end
      @(posedge clk); #1;
    end
    bus.wr_valid  = 1'b0;
    bus.req_valid = 1'b0;
    wr_taken = idx;
    check({tag, "_done"}, 32'(got_done), 32'(1));
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rnw   = 1'b0;
    bus.req_dev   = '0;
    bus.req_reg   = '0;
    bus.req_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'(1));
    check("rst_outs", 32'({bus.m_ws, bus.done, bus.wr_ready, bus.rd_valid, bus.err, bus.m_cmd}), 32'(0));
    #1 rst_n = 1'b1;

    // Write 2 bytes, with a request poked while busy
    wq = '{8'hA5, 8'h5A};
    run_xfer(1'b0, 7'h50, 8'h10, 2, -1, 0, 1'b1, "wr2");
    exp_q = '{9, 8, 8, 10};
    check_cmds("wr2");
    check("wr2_dat0", 32'(dat_log[0]), 32'h A0);
    check("wr2_dat1", 32'(dat_log[1]), 32'h 10);
    check("wr2_dat2", 32'(dat_log[2]), 32'h A5);
    check("wr2_dat3", 32'(dat_log[3]), 32'h 5A);
    check("wr2_err", 32'(err_got), 32'(0));
    check("wr2_taken", 32'(wr_taken), 32'(2));
    check("busy_accept", 32'(busy_acc), 32'(0));
    n = cmd_log.size();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("busy_no_extra_done", 32'(seen), 32'(0));
    check("busy_no_extra_cmd", 32'(cmd_log.size()), 32'(n));

    // Read 3 bytes
    wq.delete();
    rdq = '{8'h11, 8'h22, 8'h33};
    run_xfer(1'b1, 7'h50, 8'h03, 3, -1, 0, 1'b0, "rd3");
    exp_q = '{9, 8, 9, 4, 4, 22};
    check_cmds("rd3");
    check("rd3_addr_r", 32'(dat_log[2]), 32'h A1);
    check("rd3_n", 32'(rd_got.size()), 32'(3));
    for (int i = 0; i < 3 && i < rd_got.size(); i++)
      check($sformatf("rd3_byte%0d", i), 32'(rd_got[i]), 32'(8'h11 * (i + 1)));
    check("rd3_err", 32'(err_got), 32'(0));

    // Absent device: NACK on address, then STOP
    wq = '{8'h99};
    run_xfer(1'b0, 7'h51, 8'h00, 1, -1, 0, 1'b0, "nack");
    exp_q = '{9, 2};
    check_cmds("nack");
    check("nack_err", 32'(err_got), 32'(1));
    check("nack_taken", 32'(wr_taken), 32'(0));

    // wr_valid withheld 50 cycles before byte 2
    wq = '{8'h01, 8'h02};
    run_xfer(1'b0, 7'h50, 8'h40, 2, 1, 50, 1'b0, "stall");
    exp_q = '{9, 8, 8, 10};
    check_cmds("stall");
    check("stall_no_ws", 32'(stall_ws_b), 32'(stall_ws_a));
    check("stall_err", 32'(err_got), 32'(0));

    // Arbitration lost on the address byte
    wq = '{8'h77};
    alo_left = 1;
    run_xfer(1'b0, 7'h50, 8'h20, 1, -1, 0, 1'b0, "alo");
`ifdef I2C_SEQ_RETRY_EN
    exp_q = '{9, 9, 8, 10};
    check("alo_err", 32'(err_got), 32'(0));
`else
    exp_q = '{9};
    check("alo_err", 32'(err_got), 32'(2));
`endif
    check_cmds("alo");
    alo_left = 0;
    repeat (12) @(posedge clk);

    // Zero-length read: immediate reject, no bus activity
    wq.delete();
    run_xfer(1'b1, 7'h50, 8'h03, 0, -1, 0, 1'b0, "rd0");
    check("rd0_ncmd", 32'(cmd_log.size()), 32'(0));
    check("rd0_err", 32'(err_got), 32'(3));

    // Zero-length write: register byte carries the STOP
    run_xfer(1'b0, 7'h50, 8'h55, 0, -1, 0, 1'b0, "wr0");
    exp_q = '{9, 10};
    check_cmds("wr0");
    check("wr0_reg", 32'(dat_log[1]), 32'h 55);
    check("wr0_err", 32'(err_got), 32'(0));

    // Bus busy at address: err=3, no STOP
    wq = '{8'h33};
    bbl_left = 99;
    run_xfer(1'b0, 7'h50, 8'h00, 1, -1, 0, 1'b0, "bbl");
`ifdef I2C_SEQ_RETRY_EN
    exp_q = '{9, 9, 9, 9};
`else
    exp_q = '{9};
`endif
    check_cmds("bbl");
    check("bbl_err", 32'(err_got), 32'(3));
    bbl_left = 0;

    // Reset in the middle of a read
    wq.delete();
    rdq = '{8'h11, 8'h22, 8'h33};
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_rnw   = 1'b1;
    bus.req_dev   = 7'h50;
    bus.req_reg   = 8'h03;
    bus.req_len   = LEN_W'(3);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 500 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.rd_valid) seen = 1'b1;
    end
    check("rstmid_reached", 32'(seen), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_ws", 32'(bus.m_ws), 32'(0));
    check("rstmid_done", 32'(bus.done), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.m_ws) seen = 1'b1;
    end
    check("rstmid_silent", 32'(seen), 32'(0));
    check("rstmid_ready", 32'(bus.req_ready), 32'(1));
    rdq.delete();
    wq = '{8'hC3};
    run_xfer(1'b0, 7'h50, 8'h07, 1, -1, 0, 1'b0, "post");
    exp_q = '{9, 8, 10};
    check_cmds("post");
    check("post_err", 32'(err_got), 32'(0));

    check("ws_while_busy", 32'(ws_viol), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
